// File: rtl/axi4_sram_bridge.sv
// AXI4 slave to single-port sync SRAM, one INCR burst at a time; write beats 1/cycle, read beats 1 per 2 cycles.
// Backpressure: wready only in WR_DATA, B and R payloads held until bready/rready, no new AW/AR until IDLE.
module axi4_sram_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic [ID_WIDTH-1:0]       awid,
  input  logic [7:0]                awlen,
  input  logic                      wvalid,
  output logic                      wready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wlast,
  output logic                      bvalid,
  input  logic                      bready,
  output logic [ID_WIDTH-1:0]       bid,
  output logic [1:0]                bresp,
  input  logic                      arvalid,
  output logic                      arready,
  input  logic [ADDR_WIDTH-1:0]     araddr,
  input  logic [ID_WIDTH-1:0]       arid,
  input  logic [7:0]                arlen,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [ID_WIDTH-1:0]       rid,
  output logic [1:0]                rresp,
  output logic                      rlast,
  output logic                      mem_en,
  output logic [DATA_WIDTH/8-1:0]   mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int L      = $clog2(STRB_W);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_RESP,
    RD_REQ,
    RD_DATA
  } state_t;

  state_t                    state_q, state_d;
  logic                      prio_rd_q, prio_rd_d;
  logic [ID_WIDTH-1:0]       id_q, id_d;
  logic [7:0]                len_q, len_d;
  logic [7:0]                beat_q, beat_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      oor_q, oor_d;
  logic                      err_q, err_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      rfresh_q, rfresh_d;

  logic                      idle;
  logic                      aw_sel, ar_sel;
  logic                      aw_oor, ar_oor;
  logic                      last_beat;
  logic [DATA_WIDTH-1:0]     rd_val;
  logic                      unused_addr;

  assign idle      = (state_q == IDLE);
  assign last_beat = (beat_q == len_q);
  assign aw_oor    = (awaddr >> (MEM_ADDR_WIDTH + L)) != '0;
  assign ar_oor    = (araddr >> (MEM_ADDR_WIDTH + L)) != '0;
  // Sub-word address bits are dropped; only the word index and range test matter.
  assign unused_addr = ^{awaddr, araddr};

  // Contention goes to the side not served last; write wins first after reset.
  assign aw_sel  = awvalid && (!arvalid || !prio_rd_q);
  assign ar_sel  = arvalid && !aw_sel;
  assign awready = resetn && idle && !ar_sel;
  assign arready = resetn && idle && !aw_sel;

  // The first RD_DATA cycle sees the SRAM output directly; later cycles replay the capture.
  assign rd_val = oor_q    ? '0 :
                  rfresh_q ? mem_rdata : rdata_q;

  always_comb begin
    state_d   = state_q;
    prio_rd_d = prio_rd_q;
    id_d      = id_q;
    len_d     = len_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    oor_d     = oor_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    rfresh_d  = 1'b0;

    wready    = 1'b0;
    bvalid    = 1'b0;
    bid       = '0;
    bresp     = RESP_OKAY;
    rvalid    = 1'b0;
    rdata     = '0;
    rid       = '0;
    rresp     = RESP_OKAY;
    rlast     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      IDLE: begin
        if (awvalid && awready) begin
          state_d   = WR_DATA;
          prio_rd_d = 1'b1;
          id_d      = awid;
          len_d     = awlen;
          beat_d    = '0;
          addr_d    = awaddr[MEM_ADDR_WIDTH+L-1:L];
          oor_d     = aw_oor;
          err_d     = 1'b0;
        end else if (arvalid && arready) begin
          state_d   = RD_REQ;
          prio_rd_d = 1'b0;
          id_d      = arid;
          len_d     = arlen;
          beat_d    = '0;
          addr_d    = araddr[MEM_ADDR_WIDTH+L-1:L];
          oor_d     = ar_oor;
          err_d     = 1'b0;
        end
      end

      WR_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          if (!oor_q) begin
            mem_en    = 1'b1;
            mem_we    = wstrb;
            mem_addr  = addr_q;
            mem_wdata = wdata;
          end
          if (wlast != last_beat) begin
            err_d = 1'b1;
          end
          if (last_beat) begin
            state_d = WR_RESP;
          end else begin
            beat_d = beat_q + 8'd1;
            addr_d = addr_q + MEM_ADDR_WIDTH'(1);
          end
        end
      end

      WR_RESP: begin
        bvalid = 1'b1;
        bid    = id_q;
        bresp  = (oor_q || err_q) ? RESP_SLVERR : RESP_OKAY;
        if (bready) begin
          state_d = IDLE;
        end
      end

      RD_REQ: begin
        if (!oor_q) begin
          mem_en   = 1'b1;
          mem_addr = addr_q;
        end
        rfresh_d = 1'b1;
        state_d  = RD_DATA;
      end

      RD_DATA: begin
        rvalid  = 1'b1;
        rdata   = rd_val;
        rid     = id_q;
        rresp   = oor_q ? RESP_SLVERR : RESP_OKAY;
        rlast   = last_beat;
        rdata_d = rd_val;
        if (rready) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            state_d = RD_REQ;
            beat_d  = beat_q + 8'd1;
            addr_d  = addr_q + MEM_ADDR_WIDTH'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      prio_rd_q <= 1'b0;
      id_q      <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      addr_q    <= '0;
      oor_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      rfresh_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_rd_q <= prio_rd_d;
      id_q      <= id_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      oor_q     <= oor_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      rfresh_q  <= rfresh_d;
    end
  end

endmodule

// File: tb/tb_axi4_sram_bridge.sv
// Directed bench for axi4_sram_bridge with a behavioural 1024x32 synchronous SRAM.
module tb_axi4_sram_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [3:0]  rid;
  logic [1:0]  rresp;
  logic        rlast;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  axi4_sram_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_ADDR_WIDTH(10)
  ) dut (
    .clk(clk), .resetn(resetn),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // SRAM model: byte-enabled write, registered read.
  logic [31:0] mem [0:1023];
  int          mem_rd_cnt = 0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 4'h0) begin
        mem_rdata  <= mem[mem_addr];
        mem_rd_cnt <= mem_rd_cnt + 1;
      end else begin
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  longint aw_t, ar_t;
  always @(posedge clk) begin
    if (awvalid && awready) aw_t = $time;
    if (arvalid && arready) ar_t = $time;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {31'b0, awready, wready, bvalid, bid, bresp, arready, rvalid, rdata, rid, rresp,
            rlast, mem_en, mem_we, mem_addr, mem_wdata};
  endfunction

  logic [31:0] rd_dat [0:15];
  logic        rd_lst [0:15];
  logic [1:0]  rd_rsp [0:15];
  logic [3:0]  rd_ids [0:15];
  logic [1:0]  wr_rsp;
  logic [3:0]  wr_id;

  task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [31:0] d0, input logic [3:0] strb, input int last_at);
    int t;
    awvalid = 1'b1; awaddr = addr; awid = id; awlen = len;
    t = 0;
    #1;
    while (!awready && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) chk("tmo_aw", 0, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int n = 0; n <= int'(len); n++) begin
      wvalid = 1'b1; wdata = d0 + n; wstrb = strb; wlast = (n == last_at);
      t = 0;
      while (!wready && t < 200) begin @(posedge clk); #1; t++; end
      if (t >= 200) chk("tmo_w", 0, 1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    t = 0;
    while (!bvalid && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) chk("tmo_b", 0, 1);
    wr_rsp = bresp; wr_id = bid;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
    int t;
    arvalid = 1'b1; araddr = addr; arid = id; arlen = len;
    t = 0;
    #1;
    while (!arready && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) chk("tmo_ar", 0, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    rready = 1'b1;
    for (int n = 0; n <= int'(len); n++) begin
      t = 0;
      while (!rvalid && t < 200) begin @(posedge clk); #1; t++; end
      if (t >= 200) chk("tmo_r", 0, 1);
      rd_dat[n] = rdata; rd_lst[n] = rlast; rd_rsp[n] = rresp; rd_ids[n] = rid;
      @(posedge clk); #1;
    end
    rready = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  int rd_before;

  initial begin
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; rready = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    resetn = 1'b0;
    #12;
    chk("reset_outputs", all_outs(), 128'h0);
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", {awready, arready}, 2'b11);

    // 1: single write
    axi_write(32'h10, 4'h5, 8'd0, 32'hDEADBEEF, 4'hF, 0);
    chk("t1_mem4", mem[4], 32'hDEADBEEF);
    chk("t1_bresp", wr_rsp, 2'd0);
    chk("t1_bid", wr_id, 4'h5);

    // 2: four-beat read burst from words 4..7
    mem[5] = 32'h11111111; mem[6] = 32'h22222222; mem[7] = 32'h33333333;
    axi_read(32'h10, 4'h3, 8'd3);
    chk("t2_d0", rd_dat[0], 32'hDEADBEEF);
    chk("t2_d1", rd_dat[1], 32'h11111111);
    chk("t2_d2", rd_dat[2], 32'h22222222);
    chk("t2_d3", rd_dat[3], 32'h33333333);
    chk("t2_rlast", {rd_lst[0], rd_lst[1], rd_lst[2], rd_lst[3]}, 4'b0001);
    chk("t2_rresp", {rd_rsp[0], rd_rsp[1], rd_rsp[2], rd_rsp[3]}, 8'h00);
    chk("t2_rid", rd_ids[3], 4'h3);

    // 3: partial strobe merge
    mem[8] = 32'hFFFFFFFF;
    axi_write(32'h20, 4'h1, 8'd0, 32'h00001234, 4'h3, 0);
    axi_read(32'h20, 4'h1, 8'd0);
    chk("t3_merge", rd_dat[0], 32'hFFFF1234);

    // 4: burst wraps from the top word to word 0
    axi_write(32'hFFC, 4'h7, 8'd1, 32'hA0A0A0A0, 4'hF, 1);
    chk("t4_mem1023", mem[1023], 32'hA0A0A0A0);
    chk("t4_mem0", mem[0], 32'hA0A0A0A1);
    chk("t4_bresp", wr_rsp, 2'd0);

    // 5: simultaneous AW/AR after reset, read out of range
    do_reset();
    rd_before = mem_rd_cnt;
    fork
      axi_write(32'h40, 4'h2, 8'd0, 32'h00000055, 4'hF, 0);
      axi_read(32'h1000, 4'h6, 8'd1);
    join
    chk("t5_write_first", aw_t < ar_t, 1'b1);
    chk("t5_mem16", mem[16], 32'h00000055);
    chk("t5_bresp", wr_rsp, 2'd0);
    chk("t5_rresp", {rd_rsp[0], rd_rsp[1]}, 4'b1010);
    chk("t5_rdata0", {rd_dat[0], rd_dat[1]}, 64'h0);
    chk("t5_rlast", {rd_lst[0], rd_lst[1]}, 2'b01);
    chk("t5_rid", rd_ids[1], 4'h6);
    chk("t5_no_sram_read", mem_rd_cnt - rd_before, 0);

    // 6a: early wlast -> SLVERR, data still written
    axi_write(32'h80, 4'h9, 8'd3, 32'h0BAD0000, 4'hF, 1);
    chk("t6_bresp", wr_rsp, 2'd2);
    chk("t6_bid", wr_id, 4'h9);
    chk("t6_mem35", mem[35], 32'h0BAD0003);

    // 6b: reset in the middle of a held read beat
    arvalid = 1'b1; araddr = 32'h10; arid = 4'hA; arlen = 8'd3; rready = 1'b0;
    @(posedge clk); #1 arvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_rvalid_held", {rvalid, rdata}, {1'b1, 32'hDEADBEEF});
    resetn = 1'b0;
    #1;
    chk("t6_reset_outputs", all_outs(), 128'h0);
    @(posedge clk); #1 resetn = 1'b1;
    #1;
    chk("t6_idle_after_reset", {awready, arready, rvalid}, 3'b110);
    @(posedge clk); #1;
    axi_read(32'h10, 4'hB, 8'd0);
    chk("t6_read_after_reset", {rd_dat[0], rd_lst[0], rd_rsp[0]}, {32'hDEADBEEF, 1'b1, 2'b00});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
